// File: rtl/draw_line_gen.sv
// Bresenham line rasteriser: accepts two endpoints, emits one on-screen pixel per accepted
// beat with valid/ready backpressure, clips off-screen points, supports abort and done pulse.
module draw_line_gen #(
    parameter int unsigned H_RES = 160,
    parameter int unsigned V_RES = 120,
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [XW-1:0] cmd_x0_i,
    input  logic [YW-1:0] cmd_y0_i,
    input  logic [XW-1:0] cmd_x1_i,
    input  logic [YW-1:0] cmd_y1_i,
    input  logic          abort_i,
    output logic          pix_valid_o,
    input  logic          pix_ready_i,
    output logic [XW-1:0] pix_x_o,
    output logic [YW-1:0] pix_y_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned CW  = (XW > YW) ? XW : YW;
    localparam int unsigned EW  = CW + 3;  // error term width
    localparam int unsigned DXW = XW + 2;
    localparam int unsigned DYW = YW + 2;

    localparam logic [XW:0] HResW = (XW + 1)'(H_RES);
    localparam logic [YW:0] VResW = (YW + 1)'(V_RES);
    localparam logic [XW:0] XOne  = (XW + 1)'(1);
    localparam logic [YW:0] YOne  = (YW + 1)'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StDraw  = 2'd2
    } state_e;

    state_e                 state_q;
    logic [XW-1:0]          x0_q, x1_q;
    logic [YW-1:0]          y0_q, y1_q;
    logic signed [DXW-1:0]  dx_q;
    logic signed [DYW-1:0]  dy_q;
    logic                   sx_neg_q, sy_neg_q;
    logic signed [EW-1:0]   err_q;
    logic [XW:0]            cur_x_q;
    logic [YW:0]            cur_y_q;
    logic                   done_q;

    logic [XW-1:0]          x_abs;
    logic [YW-1:0]          y_abs;
    logic signed [DXW-1:0]  dx_set;
    logic signed [DYW-1:0]  dy_set;
    logic signed [EW-1:0]   err_set;
    logic signed [EW-1:0]   dx_e, dy_e;
    logic signed [EW:0]     dx_c, dy_c, e2;
    logic                   step_x, step_y;
    logic signed [EW-1:0]   err_d;
    logic [XW:0]            cur_x_d;
    logic [YW:0]            cur_y_d;
    logic                   on_screen;
    logic                   at_end;
    logic                   advance;

    // Setup-time deltas and per-step Bresenham update from the current error term.
    always_comb begin
        x_abs   = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        y_abs   = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        dx_set  = {2'b00, x_abs};
        dy_set  = -$signed({2'b00, y_abs});
        err_set = {{(EW - DXW){dx_set[DXW-1]}}, dx_set}
                + {{(EW - DYW){dy_set[DYW-1]}}, dy_set};

        dx_e = {{(EW - DXW){dx_q[DXW-1]}}, dx_q};
        dy_e = {{(EW - DYW){dy_q[DYW-1]}}, dy_q};
        dx_c = {dx_e[EW-1], dx_e};
        dy_c = {dy_e[EW-1], dy_e};
        e2   = {err_q, 1'b0};

        // Both tests use the old error so a diagonal step updates x and y together.
        step_x = (e2 >= dy_c);
        step_y = (e2 <= dx_c);

        err_d = err_q;
        if (step_x) err_d = err_d + dy_e;
        if (step_y) err_d = err_d + dx_e;

        cur_x_d = cur_x_q;
        if (step_x) cur_x_d = sx_neg_q ? (cur_x_q - XOne) : (cur_x_q + XOne);
        cur_y_d = cur_y_q;
        if (step_y) cur_y_d = sy_neg_q ? (cur_y_q - YOne) : (cur_y_q + YOne);

        on_screen = (cur_x_q < HResW) && (cur_y_q < VResW);
        at_end    = (cur_x_q == {1'b0, x1_q}) && (cur_y_q == {1'b0, y1_q});
        // Clipped points never wait for the consumer.
        advance   = !on_screen || pix_ready_i;
    end

    // Line FSM: latch command, one setup cycle, then step one point per advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        x0_q    <= cmd_x0_i;
                        y0_q    <= cmd_y0_i;
                        x1_q    <= cmd_x1_i;
                        y1_q    <= cmd_y1_i;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else begin
                        dx_q     <= dx_set;
                        dy_q     <= dy_set;
                        sx_neg_q <= !(x0_q < x1_q);
                        sy_neg_q <= !(y0_q < y1_q);
                        err_q    <= err_set;
                        cur_x_q  <= {1'b0, x0_q};
                        cur_y_q  <= {1'b0, y0_q};
                        state_q  <= StDraw;
                    end
                end
                StDraw: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else if (advance) begin
                        if (at_end) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            err_q   <= err_d;
                            cur_x_q <= cur_x_d;
                            cur_y_q <= cur_y_d;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q == StSetup) || (state_q == StDraw);
    assign pix_valid_o = (state_q == StDraw) && on_screen;
    assign pix_x_o     = cur_x_q[XW-1:0];
    assign pix_y_o     = cur_y_q[YW-1:0];
    assign done_o      = done_q;

endmodule

// File: doc/draw_line_gen.md
Name: draw_line_gen

Overview:
- Second-generation line rasteriser for the VGA graphics pipeline.
- Takes two endpoints and emits one pixel coordinate per accepted beat to the frame-buffer write path.
- Uses integer Bresenham with no divider, so it covers all eight octants, including steep and right-to-left lines.
- Generalised in resolution and coordinate width. Adds valid/ready backpressure on both sides, per-pixel clipping, abort, and a done pulse.

Parameters:
- H_RES, 160, visible width in pixels; x is on-screen when x < H_RES.
- V_RES, 120, visible height in pixels; y is on-screen when y < V_RES.
- XW, 8, x coordinate width (unsigned); must satisfy 2^XW >= H_RES.
- YW, 7, y coordinate width (unsigned); must satisfy 2^YW >= V_RES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  line command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x0  in  XW  start x.
- cmd_y0  in  YW  start y.
- cmd_x1  in  XW  end x.
- cmd_y1  in  YW  end y.
- abort  in  1  synchronous cancel of the current line.
- pix_valid  out  1  pix_x/pix_y hold an on-screen pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  XW  pixel x.
- pix_y  out  YW  pixel y.
- busy  out  1  a line is in progress (SETUP or DRAW).
- done  out  1  one-cycle pulse when a line finishes or aborts.

Behaviour:
- Reset (rst_n low, asynchronous, legal at any time including mid-line):
  - State goes to IDLE and all internal registers clear.
  - pix_valid=0, pix_x=0, pix_y=0, busy=0, done=0.
  - cmd_ready=1 once rst_n is high.
  - A line in progress is dropped and no further pixels are emitted.
- State machine: IDLE, SETUP, DRAW.
- IDLE:
  - cmd_ready=1 (a combinational decode of state==IDLE).
  - On cmd_valid && cmd_ready, latch all four coordinates and go to SETUP.
- SETUP (exactly 1 cycle), compute:
  - dx = |x1-x0| as XW+2-bit signed.
  - dy = -|y1-y0| as YW+2-bit signed.
  - sx = +1 if x0<x1, else -1.
  - sy = +1 if y0<y1, else -1.
  - err = dx+dy, with width max(XW,YW)+3 signed.
  - cur = (x0,y0), then go to DRAW.
- Latency: command accepted in cycle N, SETUP in N+1, first pix_valid at earliest in N+2.
- DRAW, each cycle evaluates cur:
  - on-screen = (cur.x < H_RES) && (cur.y < V_RES).
  - If on-screen: pix_valid=1 with pix_x/pix_y=cur. Hold it; pix_x/pix_y/pix_valid stay stable until pix_ready is high. Advance only on pix_valid && pix_ready.
  - If off-screen: pix_valid=0 and advance unconditionally in that cycle, so clipped pixels cost 1 cycle each and are never emitted.
  - Advance when cur == (x1,y1): go to IDLE and pulse done for the next cycle.
  - Advance otherwise: e2 = 2*err.
    - If e2 >= dy: err += dy, cur.x += sx.
    - If e2 <= dx: err += dx, cur.y += sy.
    - Both updates use the old err and may happen in the same cycle (diagonal step).
  - Coordinate arithmetic is XW+1 / YW+1 bits internally, so stepping never wraps. With endpoints inside 0..2^W-1, cur never leaves that range.
- Pixel count per line is max(|x1-x0|, |y1-y0|)+1 (emitted plus clipped).
  - The endpoint is always included.
  - A degenerate line (x0==x1, y0==y1) produces exactly one pixel.
- Throughput: 1 pixel/cycle when pix_ready is held high.
- abort:
  - Sampled in SETUP or DRAW; takes priority over pixel advance.
  - Next cycle: state=IDLE, pix_valid=0, done=1.
  - A pixel offered in the abort cycle counts as accepted only if pix_ready was also high that cycle.
  - abort in IDLE is ignored.
- Simultaneous events: the done cycle is IDLE, so cmd_ready=1 and a new command can be accepted in the same cycle done is high.
- busy=1 exactly while the state is SETUP or DRAW.

Test Plan:
- Shallow line, pix_ready=1: cmd (10,20)->(17,23). Required: 8 pixels (10,20),(11,20),(12,21),(13,21),(14,22),(15,22),(16,23),(17,23) on consecutive cycles starting 2 cycles after acceptance, then done one cycle after the last beat.
- Steep, reversed line: cmd (50,40)->(48,33). Required: 8 pixels with y stepping down 40..33 and x ending at 48. The last pixel is (48,33) and no pixel repeats.
- Backpressure: same as the first scenario with pix_ready toggling 1,0,0,1,... Required: identical 8-pixel sequence with pix_x/pix_y stable on every stalled cycle and no pixel dropped or duplicated.
- Clipping: H_RES=160, cmd (155,5)->(165,5). Required: 5 pixels x=155..159, done 11 cycles after the first DRAW cycle, and no pix_valid for x>=160.
- Degenerate and abort:
  - cmd (0,0)->(0,0): exactly one pixel (0,0), then done.
  - cmd (0,0)->(100,0), abort after 3 accepted pixels: pix_valid=0 next cycle, done=1, cmd_ready=1.
- Reset mid-line: assert rst_n=0 asynchronously during DRAW. Required:
  - pix_valid, busy, done and pix_x/pix_y go to 0 immediately.
  - After release cmd_ready=1 and a new line draws correctly.
